// File: rtl/stack_mem_responder_if.sv
// CPU <-> stack memory port: address, write data, write enable, and the
// responder's read data plus status/debug outputs.
interface stack_mem_responder_if #(
    parameter int unsigned STACK_WIDTH = 16,
    parameter int unsigned STACK_SIZE  = 8
) ();
    logic [STACK_SIZE-1:0]  addr;
    logic [STACK_WIDTH-1:0] din;
    logic                   wen;
    logic [STACK_WIDTH-1:0] dout;
    logic                   ready;
    logic [STACK_SIZE-1:0]  high_water;
    logic                   err_busy_wr;

    modport master (
        output addr, din, wen,
        input  dout, ready, high_water, err_busy_wr
    );

    modport slave (
        input  addr, din, wen,
        output dout, ready, high_water, err_busy_wr
    );
endinterface

// File: rtl/stack_mem_responder.sv
// Stack memory responder: zero-fill after reset, 1-cycle write-first reads,
// high-water-mark tracking and a sticky write-while-busy error flag.
module stack_mem_responder #(
    parameter int unsigned STACK_WIDTH    = 16,
    parameter int unsigned STACK_SIZE     = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    stack_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** STACK_SIZE;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state, state_next;
    logic [STACK_SIZE-1:0]   cnt, cnt_next;
    logic                    mem_we;
    logic [STACK_SIZE-1:0]   mem_waddr;
    logic [STACK_WIDTH-1:0]  mem_wdata;
    logic [STACK_WIDTH-1:0]  mem [DEPTH];
    logic [STACK_WIDTH-1:0]  dout_q;
    logic [STACK_SIZE-1:0]   high_water_q;
    logic                    err_q;

    always_ff @(posedge clk) begin
        state <= state_next;
        cnt   <= cnt_next;
    end

    // Clear sequencer owns the RAM write port until the last entry is zeroed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_we     = 1'b0;
        mem_waddr  = bus.addr;
        mem_wdata  = bus.din;
        if (reset) begin
            cnt_next = '0;
            if (CLEAR_ON_RESET) state_next = ST_CLEAR;
            else                state_next = ST_READY;
        end else begin
            case (state)
                ST_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt;
                    mem_wdata = '0;
                    cnt_next  = cnt + 1'b1;
                    if (cnt == '1) state_next = ST_READY;
                end
                ST_READY: mem_we = bus.wen;
                default:  state_next = ST_READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Write data bypasses the array so a same-address read never sees stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q       <= '0;
            high_water_q <= '0;
            err_q        <= 1'b0;
        end else if (state == ST_CLEAR) begin
            dout_q <= '0;
            if (bus.wen) err_q <= 1'b1;
        end else begin
            dout_q <= bus.wen ? bus.din : mem[bus.addr];
            if (bus.wen && (bus.addr > high_water_q)) high_water_q <= bus.addr;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.ready       = (state == ST_READY);
    assign bus.high_water  = high_water_q;
    assign bus.err_busy_wr = err_q;
endmodule
